// File: rtl/lives_tracker.sv
`default_nettype none
// ============================================================================
// Module   : lives_tracker
// Purpose  : Lives counter and play/respawn/game-over sequencer for the ball
//            engine; lives_out feeds the seven-segment displayNumber input.
// Revision : 1.0 - initial release
// ============================================================================
module lives_tracker #(
  parameter int INIT_LIVES     = 3,
  parameter int MAX_LIVES      = 3,
  parameter int RESPAWN_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ball_lost,
  input  logic       extra_life,
  output logic [3:0] lives_out,
  output logic       ball_enable,
  output logic       respawn,
  output logic       game_over
);

  localparam int               CNT_W      = $clog2(RESPAWN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(RESPAWN_CYCLES - 1);
  localparam logic [3:0]       LIVES_INIT = 4'(INIT_LIVES);
  localparam logic [3:0]       LIVES_MAX  = 4'(MAX_LIVES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAY    = 2'd1,
    S_RESPAWN = 2'd2,
    S_OVER    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       lives_q, lives_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ball_lost_q;
  logic             ball_enable_q, ball_enable_d;
  logic             respawn_q, respawn_d;
  logic             game_over_q, game_over_d;
  logic             lost_evt;

  // Only a fresh rising edge of the level counts as a loss.
  assign lost_evt = ball_lost & ~ball_lost_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      lives_q       <= LIVES_INIT;
      cnt_q         <= '0;
      ball_lost_q   <= 1'b0;
      ball_enable_q <= 1'b0;
      respawn_q     <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      cnt_q         <= cnt_d;
      ball_lost_q   <= ball_lost;
      ball_enable_q <= ball_enable_d;
      respawn_q     <= respawn_d;
      game_over_q   <= game_over_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    respawn_d = 1'b0;

    if (start) begin
      state_d   = S_PLAY;
      lives_d   = LIVES_INIT;
      cnt_d     = '0;
      respawn_d = 1'b1;
    end else begin
      unique case (state_q)
        S_PLAY: begin
          if (lost_evt) begin
            if (lives_q > 4'd1) begin
              lives_d = lives_q - 4'd1;
              state_d = S_RESPAWN;
              cnt_d   = CNT_LOAD;
            end else begin
              lives_d = 4'd0;
              state_d = S_OVER;
            end
          end else if (extra_life && (lives_q < LIVES_MAX)) begin
            lives_d = lives_q + 4'd1;
          end
        end
        S_RESPAWN: begin
          // Counter reaching zero ends the delay; loss and bonus are ignored.
          if (cnt_q == '0) begin
            state_d   = S_PLAY;
            respawn_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end

    ball_enable_d = (state_d == S_PLAY);
    game_over_d   = (state_d == S_OVER);
  end

  assign lives_out   = lives_q;
  assign ball_enable = ball_enable_q;
  assign respawn     = respawn_q;
  assign game_over   = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_lives_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_lives_tracker
// Purpose  : Directed scenarios plus randomized play checked against a
//            mode/lives reference model of lives_tracker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lives_tracker;

  localparam int INIT = 3;
  localparam int MAXL = 5;
  localparam int RC   = 4;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_RESP = 2;
  localparam int M_OVER = 3;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       ball_lost;
  logic       extra_life;
  logic [3:0] lives_out;
  logic       ball_enable;
  logic       respawn;
  logic       game_over;
  logic [6:0] outs;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: game mode, lives, cycles of delay still to run.
  int m_mode;
  int m_lives;
  int m_left;
  bit m_prev;
  bit m_resp;

  lives_tracker #(
    .INIT_LIVES    (INIT),
    .MAX_LIVES     (MAXL),
    .RESPAWN_CYCLES(RC)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ball_lost  (ball_lost),
    .extra_life (extra_life),
    .lives_out  (lives_out),
    .ball_enable(ball_enable),
    .respawn    (respawn),
    .game_over  (game_over)
  );

  assign outs = {lives_out, ball_enable, respawn, game_over};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_lives = INIT;
    m_left  = 0;
    m_prev  = 1'b0;
    m_resp  = 1'b0;
  endtask

  task automatic model_clock(input bit s, input bit bl, input bit el);
    bit evt;
    evt    = bl && !m_prev;
    m_prev = bl;
    m_resp = 1'b0;
    if (s) begin
      m_mode  = M_PLAY;
      m_lives = INIT;
      m_left  = 0;
      m_resp  = 1'b1;
    end else if (m_mode == M_PLAY) begin
      if (evt) begin
        if (m_lives > 1) begin
          m_lives = m_lives - 1;
          m_mode  = M_RESP;
          m_left  = RC;
        end else begin
          m_lives = 0;
          m_mode  = M_OVER;
        end
      end else if (el) begin
        m_lives = (m_lives + 1 > MAXL) ? MAXL : m_lives + 1;
      end
    end else if (m_mode == M_RESP) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_mode = M_PLAY;
        m_resp = 1'b1;
      end
    end
  endtask

  function automatic logic [6:0] model_outs();
    logic [3:0] l;
    l = 4'(m_lives);
    return {l, (m_mode == M_PLAY), m_resp, (m_mode == M_OVER)};
  endfunction

  task automatic step(input bit s, input bit bl, input bit el);
    start      = s;
    ball_lost  = bl;
    extra_life = el;
    @(posedge clk);
    model_clock(s, bl, el);
    #1;
    check("cycle", outs, model_outs());
  endtask

  // Reset asserted between edges must clear outputs without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check(tag, outs, {4'(INIT), 3'b000});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int         low;
    bit         bl;
    logic [3:0] exp_l [4];

    rst_n      = 1'b0;
    start      = 1'b0;
    ball_lost  = 1'b0;
    extra_life = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset", outs, {4'd3, 3'b000});
    @(negedge clk);
    rst_n = 1'b1;

    // Start from IDLE: one respawn pulse alongside ball_enable.
    step(1'b0, 1'b0, 1'b1);
    check("idle_ignores", outs, {4'd3, 3'b000});
    step(1'b1, 1'b0, 1'b0);
    check("t1_start", outs, {4'd3, 3'b110});
    step(1'b0, 1'b0, 1'b0);
    check("t1_resp_low", 7'(respawn), 7'd0);

    // Held ball_lost: one decrement, exactly RC cycles disabled.
    low = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (!ball_enable) low++;
    end
    check("t2_low_cycles", 7'(low), 7'(RC));
    check("t2_lives", 7'(lives_out), 7'd2);
    step(1'b0, 1'b0, 1'b0);

    // Lose remaining lives down to game over, then restart.
    step(1'b0, 1'b1, 1'b0);
    check("t3_lives1", 7'(lives_out), 7'd1);
    repeat (RC) step(1'b0, 1'b0, 1'b0);
    check("t3_back_play", 7'(ball_enable), 7'd1);
    step(1'b0, 1'b1, 1'b0);
    check("t3_over", outs, {4'd0, 3'b001});
    for (int i = 0; i < 100; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("t3_over_hold", outs, {4'd0, 3'b001});
    step(1'b1, 1'b0, 1'b0);
    check("t3_restart", outs, {4'd3, 3'b110});

    // Extra lives saturate at MAXL; ignored during respawn.
    exp_l[0] = 4'd4; exp_l[1] = 4'd5; exp_l[2] = 4'd5; exp_l[3] = 4'd5;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1);
      check("t4_extra", 7'(lives_out), 7'(exp_l[i]));
    end
    step(1'b0, 1'b1, 1'b0);
    check("t4_loss", 7'(lives_out), 7'd4);
    repeat (RC) step(1'b0, 1'b0, 1'b1);
    check("t4_resp_extra", outs, {4'd4, 3'b110});

    // Simultaneous loss+bonus, and start+loss.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (RC) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("t5_loss_beats_extra", outs, {4'd1, 3'b000});
    repeat (RC) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("t5_start_beats_loss", outs, {4'd3, 3'b110});
    step(1'b0, 1'b1, 1'b0);
    check("t5_no_second_loss", outs, {4'd3, 3'b100});

    // Asynchronous reset mid-respawn, then IDLE needs start.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    async_reset("t6_async");
    step(1'b0, 1'b0, 1'b1);
    check("t6_idle", outs, {4'd3, 3'b000});
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Randomized play against the model.
    bl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) bl = ~bl;
      step(($urandom_range(0, 63) == 0), bl, ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 299) == 0) async_reset("rand_async");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
